// File: rtl/risc_ctrl.sv
// Instruction-cycle sequencer for the 8-bit RISC core: fetches the two-byte
// instruction, latches its opcode and issues registered control strobes.
module risc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       alu_ena,
  output logic       load_acc,
  output logic       datactl_ena,
  output logic       halt,
  output logic       fetch
);

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_S0   = 4'd1;
  localparam logic [3:0] ST_S1   = 4'd2;
  localparam logic [3:0] ST_S2   = 4'd3;
  localparam logic [3:0] ST_S3   = 4'd4;
  localparam logic [3:0] ST_S4   = 4'd5;
  localparam logic [3:0] ST_S5   = 4'd6;
  localparam logic [3:0] ST_S6   = 4'd7;
  localparam logic [3:0] ST_S7   = 4'd8;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  logic [3:0] state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       skip_q, skip_d;

  logic rd_q, rd_d;
  logic wr_q, wr_d;
  logic load_ir_q, load_ir_d;
  logic inc_pc_q, inc_pc_d;
  logic load_pc_q, load_pc_d;
  logic alu_ena_q, alu_ena_d;
  logic load_acc_q, load_acc_d;
  logic datactl_ena_q, datactl_ena_d;
  logic halt_q, halt_d;
  logic fetch_q, fetch_d;

  logic is_alu;
  logic is_sto;
  logic is_jmp;
  logic is_hlt;
  logic do_skip;

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = ena ? ST_S0 : ST_IDLE;
      ST_S0:   state_d = ST_S1;
      ST_S1:   state_d = ST_S2;
      ST_S2:   state_d = ST_S3;
      ST_S3:   state_d = ST_S4;
      ST_S4:   state_d = ST_S5;
      ST_S5:   state_d = ST_S6;
      ST_S6:   state_d = ST_S7;
      ST_S7:   state_d = ena ? ST_S0 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // opcode and zero are sampled on one edge each; everything else ignores them.
  assign op_d   = (state_q == ST_S2) ? opcode : op_q;
  assign skip_d = (state_q == ST_S3) ? zero : skip_q;

  // Decode uses the values being latched this edge so the S3/S4 strobes are not a cycle late.
  assign is_alu  = (op_d == OP_ADD) || (op_d == OP_AND) ||
                   (op_d == OP_XOR) || (op_d == OP_LDA);
  assign is_sto  = (op_d == OP_STO);
  assign is_jmp  = (op_d == OP_JMP);
  assign is_hlt  = (op_d == OP_HLT);
  assign do_skip = (op_d == OP_SKZ) && skip_d;

  always_comb begin
    rd_d          = 1'b0;
    wr_d          = 1'b0;
    load_ir_d     = 1'b0;
    inc_pc_d      = 1'b0;
    load_pc_d     = 1'b0;
    alu_ena_d     = 1'b0;
    load_acc_d    = 1'b0;
    datactl_ena_d = 1'b0;
    halt_d        = 1'b0;
    fetch_d       = 1'b0;
    case (state_d)
      ST_S0, ST_S1: begin
        rd_d      = 1'b1;
        load_ir_d = 1'b1;
        inc_pc_d  = 1'b1;
        fetch_d   = 1'b1;
      end
      ST_S2: fetch_d = 1'b1;
      ST_S3: begin
        fetch_d = 1'b1;
        halt_d  = is_hlt;
      end
      ST_S4: begin
        rd_d          = is_alu;
        alu_ena_d     = is_alu;
        datactl_ena_d = is_sto;
        load_pc_d     = is_jmp;
        inc_pc_d      = do_skip;
        halt_d        = is_hlt;
      end
      ST_S5: begin
        rd_d          = is_alu;
        load_acc_d    = is_alu;
        datactl_ena_d = is_sto;
        wr_d          = is_sto;
        load_pc_d     = is_jmp;
        inc_pc_d      = do_skip;
        halt_d        = is_hlt;
      end
      ST_S6: begin
        datactl_ena_d = is_sto;
        halt_d        = is_hlt;
      end
      ST_S7: halt_d = is_hlt;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_HLT;
      skip_q        <= 1'b0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      load_ir_q     <= 1'b0;
      inc_pc_q      <= 1'b0;
      load_pc_q     <= 1'b0;
      alu_ena_q     <= 1'b0;
      load_acc_q    <= 1'b0;
      datactl_ena_q <= 1'b0;
      halt_q        <= 1'b0;
      fetch_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      skip_q        <= skip_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      load_ir_q     <= load_ir_d;
      inc_pc_q      <= inc_pc_d;
      load_pc_q     <= load_pc_d;
      alu_ena_q     <= alu_ena_d;
      load_acc_q    <= load_acc_d;
      datactl_ena_q <= datactl_ena_d;
      halt_q        <= halt_d;
      fetch_q       <= fetch_d;
    end
  end

  assign rd          = rd_q;
  assign wr          = wr_q;
  assign load_ir     = load_ir_q;
  assign inc_pc      = inc_pc_q;
  assign load_pc     = load_pc_q;
  assign alu_ena     = alu_ena_q;
  assign load_acc    = load_acc_q;
  assign datactl_ena = datactl_ena_q;
  assign halt        = halt_q;
  assign fetch       = fetch_q;

endmodule

// File: tb/tb_risc_ctrl.sv
// Scoreboard bench for risc_ctrl: per-cycle expected strobe vectors are queued
// by the driver and checked by an independent negedge monitor.
module tb_risc_ctrl;

  localparam logic [9:0] RD   = 10'b10_0000_0000;
  localparam logic [9:0] WR   = 10'b01_0000_0000;
  localparam logic [9:0] LIR  = 10'b00_1000_0000;
  localparam logic [9:0] INC  = 10'b00_0100_0000;
  localparam logic [9:0] LPC  = 10'b00_0010_0000;
  localparam logic [9:0] ALU  = 10'b00_0001_0000;
  localparam logic [9:0] LAC  = 10'b00_0000_1000;
  localparam logic [9:0] DAT  = 10'b00_0000_0100;
  localparam logic [9:0] HLTB = 10'b00_0000_0010;
  localparam logic [9:0] FET  = 10'b00_0000_0001;
  localparam logic [9:0] NONE = 10'b00_0000_0000;
  localparam logic [9:0] F01  = RD | LIR | INC | FET;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110, JMP = 3'b111;

  logic clk = 1'b0;
  logic rst_n, ena, zero;
  logic [2:0] opcode;
  logic rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc, datactl_ena, halt, fetch;
  logic [9:0] outs;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int         tag;
    logic [9:0] v;
  } exp_t;
  exp_t exp_q[$];

  // Tiny datapath driven by the strobes: PC, ALU register and accumulator.
  logic [12:0] pc_m;
  logic [12:0] ir_addr;
  logic [7:0]  alu_m, acc_m, dbus;
  logic [2:0]  cur_op;

  risc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero),
    .rd(rd), .wr(wr), .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc),
    .alu_ena(alu_ena), .load_acc(load_acc), .datactl_ena(datactl_ena),
    .halt(halt), .fetch(fetch)
  );

  assign outs = {rd, wr, load_ir, inc_pc, load_pc, alu_ena, load_acc, datactl_ena, halt, fetch};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_m <= '0;
    else if (inc_pc) pc_m <= pc_m + 13'd1;
    else if (load_pc) pc_m <= ir_addr;
  end

  always @(posedge clk) begin
    if (alu_ena) alu_m <= (cur_op == LDA) ? dbus : acc_m + dbus;
    if (load_acc) acc_m <= alu_m;
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (outs !== e.v) begin
        errors++;
        $display("FAIL strobes cyc=%0d got=%b want=%b (rd wr ir inc lpc alu lacc dat hlt fet)",
                 cyc, outs, e.v);
      end
    end
    if (rst_n) begin
      checks++;
      if ((rd && wr) || (inc_pc && load_pc) || (wr && !datactl_ena)) begin
        errors++;
        $display("FAIL invariant cyc=%0d got=%b", cyc, outs);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Called at posedge+2: drives inputs sampled by the next edge and queues
  // the strobes expected after that edge.
  task automatic step(input logic en, input logic [2:0] op, input logic z, input logic [9:0] e);
    exp_t x;
    ena = en;
    opcode = op;
    zero = z;
    x.tag = cyc + 1;
    x.v = e;
    exp_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic instr(input string name, input logic [2:0] op, input logic z, input logic drop,
                       input int nsteps, input logic [9:0] e3, input logic [9:0] e4,
                       input logic [9:0] e5, input logic [9:0] e6, input logic [9:0] e7);
    logic [9:0] ev [8];
    ev[0] = F01; ev[1] = F01; ev[2] = FET; ev[3] = e3;
    ev[4] = e4;  ev[5] = e5;  ev[6] = e6;  ev[7] = e7;
    cur_op = op;
    $display("instr %s op=%b zero@S3=%b drop_ena=%b steps=%0d", name, op, z, drop, nsteps);
    for (int i = 0; i < nsteps; i++)
      step((drop && i >= 3) ? 1'b0 : 1'b1, (i == 3) ? op : ~op, (i == 4) ? z : ~z, ev[i]);
  endtask

  initial begin
    logic [12:0] p;
    rst_n = 1'b0; ena = 1'b0; opcode = 3'b000; zero = 1'b0;
    dbus = 8'h00; ir_addr = 13'h0000; cur_op = HLT;
    #1;
    chk("reset outputs", 32'(outs), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    step(1'b0, 3'b000, 1'b0, NONE);

    dbus = 8'h05; p = pc_m;
    instr("LDA 05", LDA, 1'b0, 1'b0, 8, FET, RD | ALU, RD | LAC, NONE, NONE);
    chk("LDA acc", 32'(acc_m), 32'h05);
    chk("LDA pc+2", 32'(pc_m), 32'(p + 13'd2));

    dbus = 8'h03; p = pc_m;
    instr("ADD 03", ADD, 1'b1, 1'b0, 8, FET, RD | ALU, RD | LAC, NONE, NONE);
    chk("ADD acc", 32'(acc_m), 32'h08);
    chk("ADD pc+2", 32'(pc_m), 32'(p + 13'd2));

    p = pc_m;
    instr("SKZ z=1", SKZ, 1'b1, 1'b0, 8, FET, INC, INC, NONE, NONE);
    chk("SKZ taken pc+4", 32'(pc_m), 32'(p + 13'd4));

    p = pc_m;
    instr("SKZ z=0", SKZ, 1'b0, 1'b0, 8, FET, NONE, NONE, NONE, NONE);
    chk("SKZ not taken pc+2", 32'(pc_m), 32'(p + 13'd2));

    ir_addr = 13'h0040;
    instr("JMP 0040", JMP, 1'b0, 1'b0, 8, FET, LPC, LPC, NONE, NONE);
    chk("JMP pc", 32'(pc_m), 32'h0040);

    p = pc_m;
    instr("HLT", HLT, 1'b0, 1'b0, 8, FET | HLTB, HLTB, HLTB, HLTB, HLTB);
    chk("HLT pc+2", 32'(pc_m), 32'(p + 13'd2));

    dbus = 8'h5A;
    instr("LDA 5A", LDA, 1'b0, 1'b0, 8, FET, RD | ALU, RD | LAC, NONE, NONE);
    chk("LDA after HLT acc", 32'(acc_m), 32'h5A);

    instr("STO ena drop", STO, 1'b0, 1'b1, 8, FET, DAT, DAT | WR, DAT, NONE);
    step(1'b0, 3'b000, 1'b0, NONE);
    dbus = 8'h01;
    instr("ADD 01 restart", ADD, 1'b0, 1'b0, 8, FET, RD | ALU, RD | LAC, NONE, NONE);
    chk("ADD after idle acc", 32'(acc_m), 32'h5B);

    instr("STO reset", STO, 1'b0, 1'b0, 6, FET, DAT, DAT | WR, DAT, NONE);
    @(negedge clk); #1;
    chk("wr high in S5", 32'(wr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset drops outputs", 32'(outs), 32'd0);
    @(posedge clk); #2;
    step(1'b1, 3'b000, 1'b0, NONE);
    step(1'b1, 3'b000, 1'b0, NONE);
    rst_n = 1'b1;
    dbus = 8'h02; p = pc_m;
    instr("ADD 02 after reset", ADD, 1'b0, 1'b0, 8, FET, RD | ALU, RD | LAC, NONE, NONE);
    chk("ADD after reset acc", 32'(acc_m), 32'h5D);
    chk("ADD after reset pc", 32'(pc_m), 32'(p + 13'd2));

    @(negedge clk); #1;
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
